// File: rtl/vga_pixel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Text-mode attribute fields and the shared pixel colour rule.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int         c_ATTR_BLINK  = 7;
    localparam int         c_ATTR_BG_MSB = 6;
    localparam int         c_ATTR_BG_LSB = 4;
    localparam int         c_ATTR_FG_MSB = 3;
    localparam int         c_ATTR_FG_LSB = 0;
    localparam logic [3:0] c_RGBI_BLACK  = 4'b0000;

    // Blinking text falls back to bg in the "on" phase; the cursor inverts the pixel.
    function automatic logic [3:0] attr_colour(
        input logic       pix,
        input logic [7:0] attr,
        input logic       blink_ph,
        input logic       cur
    );
        logic [3:0] w_bg;
        logic [3:0] w_fg;
        logic       w_p;
        w_bg = {1'b0, attr[c_ATTR_BG_MSB:c_ATTR_BG_LSB]};
        w_fg = (attr[c_ATTR_BLINK] & blink_ph) ? w_bg : attr[c_ATTR_FG_MSB:c_ATTR_FG_LSB];
        w_p  = pix ^ (cur & blink_ph);
        return w_p ? w_fg : w_bg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_shifter_if
// Description : Character/sync inputs and pixel/sync outputs of the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_shifter_if;

    logic       shload_n;
    logic       blank;
    logic       vblank_n;
    logic       hsync;
    logic       vsync;
    logic [7:0] font_data;
    logic [7:0] attr;
    logic       cursor_hit;
    logic [3:0] rgbi;
    logic       hsync_o;
    logic       vsync_o;
    logic       blink_ph;

    modport master (
        output shload_n, blank, vblank_n, hsync, vsync, font_data, attr, cursor_hit,
        input  rgbi, hsync_o, vsync_o, blink_ph
    );

    modport slave (
        input  shload_n, blank, vblank_n, hsync, vsync, font_data, attr, cursor_hit,
        output rgbi, hsync_o, vsync_o, blink_ph
    );

endinterface
`default_nettype wire

// File: rtl/vga_pixel_shifter_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_delay
// Description : Fixed-length delay line for a sync signal, resets to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
    parameter int   DLY  = 2,
    parameter logic IDLE = 1'b1
) (
    input  wire logic pclk,
    input  wire logic rst_n,
    input  wire logic i_din,
    output logic      o_dout
);

    logic [DLY-1:0] r_line;

    generate
        if (DLY == 1) begin : g_single
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n) r_line <= IDLE;
                else        r_line <= i_din;
            end
        end else begin : g_chain
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n) r_line <= {DLY{IDLE}};
                else        r_line <= {r_line[DLY-2:0], i_din};
            end
        end
    endgenerate

    assign o_dout = r_line[DLY-1];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_shifter
// Description : Text-mode pixel serializer with sync alignment and blink timer.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_shifter
    import vga_pkg::*;
#(
    parameter int   SYNC_DLY  = 2,
    parameter logic SYNC_IDLE = 1'b1,
    parameter int   BLINK_BIT = 4
) (
    input wire logic           pclk,
    input wire logic           rst_n,
    vga_pixel_shifter_if.slave bus
);

    logic [7:0] r_shreg;
    logic [7:0] r_attr;
    logic       r_blank;
    logic       r_cur;
    logic [3:0] r_rgbi;
    logic [7:0] r_frame_cnt;
    logic       r_vblank_n_d;
    logic       w_blink_ph;

    assign w_blink_ph = r_frame_cnt[BLINK_BIT];

    // A load edge emits the new cell's leftmost pixel straight from the inputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= 8'd0;
            r_attr  <= 8'd0;
            r_blank <= 1'b1;
            r_cur   <= 1'b0;
            r_rgbi  <= c_RGBI_BLACK;
        end else if (!bus.shload_n) begin
            r_shreg <= bus.font_data;
            r_attr  <= bus.attr;
            r_blank <= bus.blank;
            r_cur   <= bus.cursor_hit;
            r_rgbi  <= bus.blank ? c_RGBI_BLACK
                                 : attr_colour(bus.font_data[7], bus.attr, w_blink_ph, bus.cursor_hit);
        end else begin
            r_shreg <= {r_shreg[6:0], 1'b0};
            r_rgbi  <= r_blank ? c_RGBI_BLACK
                               : attr_colour(r_shreg[6], r_attr, w_blink_ph, r_cur);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblank_n_d <= 1'b1;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_vblank_n_d <= bus.vblank_n;
            if (r_vblank_n_d && !bus.vblank_n)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign bus.rgbi     = r_rgbi;
    assign bus.blink_ph = w_blink_ph;

    vga_sync_delay #(.DLY(SYNC_DLY), .IDLE(SYNC_IDLE)) u_hsync_dly (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .i_din  (bus.hsync),
        .o_dout (bus.hsync_o)
    );

    vga_sync_delay #(.DLY(SYNC_DLY), .IDLE(SYNC_IDLE)) u_vsync_dly (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .i_din  (bus.vsync),
        .o_dout (bus.vsync_o)
    );

endmodule
`default_nettype wire
